// File: rtl/pong_pkg.sv
// Pong playfield geometry, ball state and direction encodings.
// Shared by the ball motion stage and its serve timer.
package pong_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int BALL_SIZE   = 8;
  localparam int PADDLE_W    = 8;
  localparam int PADDLE_H    = 64;
  localparam int LEFT_X      = 16;
  localparam int RIGHT_X     = 616;
  localparam int SPEED       = 2;
  localparam int SERVE_DELAY = 60;

  localparam int LEFT_FACE = LEFT_X + PADDLE_W;
  localparam int SRV_W     = $clog2(SERVE_DELAY + 1);

  // 11-bit forms keep every compare free of wraparound
  localparam logic [10:0] SPEED_W     = 11'(SPEED);
  localparam logic [10:0] BALL_W      = 11'(BALL_SIZE);
  localparam logic [10:0] PAD_H_W     = 11'(PADDLE_H);
  localparam logic [10:0] LEFT_FACE_W = 11'(LEFT_FACE);
  localparam logic [10:0] RIGHT_X_W   = 11'(RIGHT_X);
  localparam logic [10:0] X_MAX_W     = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_MAX_W     = 11'(SCREEN_H - BALL_SIZE);

  localparam logic [9:0] SPEED_10     = 10'(SPEED);
  localparam logic [9:0] CENTER_X     = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0] CENTER_Y     = 10'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam logic [9:0] LEFT_STOP_X  = 10'(LEFT_FACE);
  localparam logic [9:0] RIGHT_STOP_X = 10'(RIGHT_X - BALL_SIZE);
  localparam logic [9:0] Y_MAX        = 10'(SCREEN_H - BALL_SIZE);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    HALT  = 2'd2
  } ball_state_t;

  // NEG = left / up, POS = right / down
  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

endpackage

// File: rtl/serve_timer.sv
// Counts frame ticks while start is held; done fires on the
// SERVE_DELAY-th tick and the count wraps back to zero.
module serve_timer
  import pong_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tick,
  output logic done
);

  localparam logic [SRV_W-1:0] LAST = SRV_W'(SERVE_DELAY - 1);
  localparam logic [SRV_W-1:0] ONE  = SRV_W'(1);

  logic [SRV_W-1:0] cnt_q;
  logic [SRV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    done  = 1'b0;
    if (!start) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ball_motion.sv
// Pong ball physics: per-frame motion, wall and paddle reflection,
// score pulses, serve hold after a miss, freeze on game over.
module ball_motion
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       game_over,
  input  logic [9:0] paddle_left_y,
  input  logic [9:0] paddle_right_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       serving,
  output logic       hit_left,
  output logic       hit_right,
  output logic       miss_left,
  output logic       miss_right
);

  ball_state_t state_q, state_d;
  dir_t        dx_q, dx_d;
  dir_t        dy_q, dy_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hl_q, hl_d;
  logic        hr_q, hr_d;
  logic        ml_q, ml_d;
  logic        mr_q, mr_d;

  logic        srv_start;
  logic        srv_done;

  logic [10:0] x, y, pl, pr;
  logic [10:0] x_inc, y_inc;
  logic        ovl_l, ovl_r;
  logic        hit_l, hit_r, mis_l, mis_r;

  serve_timer u_serve_timer (
    .clk   (clk),
    .reset (reset),
    .start (srv_start),
    .tick  (frame_tick),
    .done  (srv_done)
  );

  assign x     = {1'b0, x_q};
  assign y     = {1'b0, y_q};
  assign pl    = {1'b0, paddle_left_y};
  assign pr    = {1'b0, paddle_right_y};
  assign x_inc = x + SPEED_W;
  assign y_inc = y + SPEED_W;

  // Paddle overlap is judged on the pre-move ball row
  assign ovl_l = (y + BALL_W > pl) && (y < pl + PAD_H_W);
  assign ovl_r = (y + BALL_W > pr) && (y < pr + PAD_H_W);

  assign hit_l = (dx_q == DIR_NEG) && (x >= LEFT_FACE_W)
              && (x < LEFT_FACE_W + SPEED_W) && ovl_l;
  assign hit_r = (dx_q == DIR_POS) && (x + BALL_W <= RIGHT_X_W)
              && (x_inc + BALL_W > RIGHT_X_W) && ovl_r;
  assign mis_l = (dx_q == DIR_NEG) && (x < SPEED_W);
  assign mis_r = (dx_q == DIR_POS) && (x_inc > X_MAX_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SERVE;
      dx_q    <= DIR_POS;
      dy_q    <= DIR_POS;
      x_q     <= CENTER_X;
      y_q     <= CENTER_Y;
      hl_q    <= 1'b0;
      hr_q    <= 1'b0;
      ml_q    <= 1'b0;
      mr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hl_q    <= hl_d;
      hr_q    <= hr_d;
      ml_q    <= ml_d;
      mr_q    <= mr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    x_d     = x_q;
    y_d     = y_q;
    hl_d    = 1'b0;
    hr_d    = 1'b0;
    ml_d    = 1'b0;
    mr_d    = 1'b0;
    if (game_over) begin
      state_d = HALT;
    end else if (frame_tick) begin
      unique case (state_q)
        SERVE: begin
          if (srv_done) state_d = PLAY;
        end
        PLAY: begin
          if (dy_q == DIR_NEG) begin
            if (y < SPEED_W) begin
              y_d  = '0;
              dy_d = DIR_POS;
            end else begin
              y_d = y_q - SPEED_10;
            end
          end else if (y_inc > Y_MAX_W) begin
            y_d  = Y_MAX;
            dy_d = DIR_NEG;
          end else begin
            y_d = y_inc[9:0];
          end
          unique case (1'b1)
            hit_l: begin
              x_d  = LEFT_STOP_X;
              dx_d = DIR_POS;
              hl_d = 1'b1;
            end
            hit_r: begin
              x_d  = RIGHT_STOP_X;
              dx_d = DIR_NEG;
              hr_d = 1'b1;
            end
            mis_l: begin
              x_d     = CENTER_X;
              y_d     = CENTER_Y;
              dx_d    = DIR_NEG;
              ml_d    = 1'b1;
              state_d = SERVE;
            end
            mis_r: begin
              x_d     = CENTER_X;
              y_d     = CENTER_Y;
              dx_d    = DIR_POS;
              mr_d    = 1'b1;
              state_d = SERVE;
            end
            default: begin
              if (dx_q == DIR_POS) x_d = x_inc[9:0];
              else                 x_d = x_q - SPEED_10;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    serving    = (state_q == SERVE);
    srv_start  = (state_q == SERVE) && !game_over;
    ball_x     = x_q;
    ball_y     = y_q;
    hit_left   = hl_q;
    hit_right  = hr_q;
    miss_left  = ml_q;
    miss_right = mr_q;
  end

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios plus a
// randomized run against a plain-arithmetic playfield model.
module tb_ball_motion;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       game_over;
  logic [9:0] paddle_left_y;
  logic [9:0] paddle_right_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       serving;
  logic       hit_left;
  logic       hit_right;
  logic       miss_left;
  logic       miss_right;

  int n_checks = 0;
  int n_errors = 0;

  // model state: position, direction (+1/-1), mode 0 serve 1 play 2 halt
  int mx, my, mdx, mdy, mmode, mcnt;
  bit e_hl, e_hr, e_ml, e_mr;

  ball_motion dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .game_over      (game_over),
    .paddle_left_y  (paddle_left_y),
    .paddle_right_y (paddle_right_y),
    .ball_x         (ball_x),
    .ball_y         (ball_y),
    .serving        (serving),
    .hit_left       (hit_left),
    .hit_right      (hit_right),
    .miss_left      (miss_left),
    .miss_right     (miss_right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mx = 316; my = 236; mdx = 1; mdy = 1; mmode = 0; mcnt = 0;
    e_hl = 0; e_hr = 0; e_ml = 0; e_mr = 0;
  endtask

  task automatic model_tick(input int pl, input int pr);
    int nx, ny, ndx, ndy;
    e_hl = 0; e_hr = 0; e_ml = 0; e_mr = 0;
    if (game_over) begin
      mmode = 2;
      return;
    end
    if (mmode == 0) begin
      mcnt++;
      if (mcnt == 60) begin
        mcnt = 0;
        mmode = 1;
      end
      return;
    end
    if (mmode != 1) return;
    ny = my + 2 * mdy;
    ndy = mdy;
    if (ny < 0) begin ny = 0; ndy = 1; end
    else if (ny > 472) begin ny = 472; ndy = -1; end
    nx = mx + 2 * mdx;
    ndx = mdx;
    if (mdx < 0 && mx >= 24 && nx < 24 && my + 8 > pl && my < pl + 64) begin
      nx = 24; ndx = 1; e_hl = 1;
    end else if (mdx > 0 && mx + 8 <= 616 && nx + 8 > 616
                 && my + 8 > pr && my < pr + 64) begin
      nx = 608; ndx = -1; e_hr = 1;
    end else if (nx < 0) begin
      nx = 316; ny = 236; ndx = -1; e_ml = 1; mmode = 0;
    end else if (nx > 632) begin
      nx = 316; ny = 236; ndx = 1; e_mr = 1; mmode = 0;
    end
    mx = nx; my = ny; mdx = ndx; mdy = ndy;
  endtask

  task automatic do_tick(input int gap);
    repeat (gap) @(negedge clk);
    frame_tick = 1'b1;
    model_tick(int'(paddle_left_y), int'(paddle_right_y));
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  function automatic logic [9:0] track(input int yy);
    int p;
    p = yy - 20;
    if (p < 0) p = 0;
    if (p > 415) p = 415;
    return 10'(p);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({ball_x, ball_y, serving} !== {10'd316, 10'd236, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_pos: got x=%0d y=%0d srv=%0b want 316 236 1",
               ball_x, ball_y, serving);
    end
    n_checks++;
    if ({hit_left, hit_right, miss_left, miss_right} !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_pulses: got %b want 0000",
               {hit_left, hit_right, miss_left, miss_right});
    end
  endtask

  task automatic test_serve_timing();
    for (int i = 1; i <= 60; i++) begin
      do_tick(i % 3);
      if (i == 59) begin
        n_checks++;
        if (serving !== 1'b1) begin
          n_errors++;
          $display("FAIL serve_59: got serving=%0b want 1", serving);
        end
      end
    end
    n_checks++;
    if ({serving, ball_x, ball_y} !== {1'b0, 10'd316, 10'd236}) begin
      n_errors++;
      $display("FAIL serve_end: got srv=%0b x=%0d y=%0d want 0 316 236",
               serving, ball_x, ball_y);
    end
    do_tick(0);
    n_checks++;
    if ({ball_x, ball_y} !== {10'd318, 10'd238}) begin
      n_errors++;
      $display("FAIL first_move: got x=%0d y=%0d want 318 238", ball_x, ball_y);
    end
  endtask

  task automatic test_bottom_wall();
    int lim;
    int want_y [3] = '{472, 472, 470};
    lim = 0;
    while (!(my == 470 && mdy > 0) && lim < 400) begin
      paddle_right_y = track(my);
      do_tick(0);
      lim++;
    end
    n_checks++;
    if (ball_y !== 10'd470) begin
      n_errors++;
      $display("FAIL wall_reach: got y=%0d want 470", ball_y);
    end
    for (int k = 0; k < 3; k++) begin
      do_tick(1);
      n_checks++;
      if (ball_y !== 10'(want_y[k]) ||
          {hit_left, hit_right, miss_left, miss_right} !== 4'b0) begin
        n_errors++;
        $display("FAIL wall_step%0d: got y=%0d pulses=%b want %0d 0000",
                 k, ball_y, {hit_left, hit_right, miss_left, miss_right},
                 want_y[k]);
      end
    end
  endtask

  task automatic test_left_hit();
    int lim;
    lim = 0;
    while (!(mx == 26 && mdx < 0) && lim < 1000) begin
      paddle_right_y = track(my);
      do_tick(0);
      lim++;
    end
    n_checks++;
    if (ball_x !== 10'd26) begin
      n_errors++;
      $display("FAIL lhit_reach: got x=%0d want 26", ball_x);
    end
    paddle_left_y = track(my);
    do_tick(0);
    n_checks++;
    if (ball_x !== 10'd24 || hit_left !== 1'b0) begin
      n_errors++;
      $display("FAIL lhit_t1: got x=%0d hit=%0b want 24 0", ball_x, hit_left);
    end
    do_tick(0);
    n_checks++;
    if (ball_x !== 10'd24 || hit_left !== 1'b1) begin
      n_errors++;
      $display("FAIL lhit_t2: got x=%0d hit=%0b want 24 1", ball_x, hit_left);
    end
    @(negedge clk);
    n_checks++;
    if (hit_left !== 1'b0) begin
      n_errors++;
      $display("FAIL lhit_width: got hit=%0b want 0", hit_left);
    end
    do_tick(0);
    n_checks++;
    if (ball_x !== 10'd26 || hit_left !== 1'b0) begin
      n_errors++;
      $display("FAIL lhit_t3: got x=%0d hit=%0b want 26 0", ball_x, hit_left);
    end
  endtask

  task automatic test_left_miss();
    int lim;
    lim = 0;
    e_ml = 0;
    while (!e_ml && lim < 2000) begin
      paddle_right_y = track(my);
      paddle_left_y  = (my < 236) ? 10'd400 : 10'd0;
      do_tick(0);
      lim++;
    end
    n_checks++;
    if ({miss_left, ball_x, ball_y, serving} !==
        {1'b1, 10'd316, 10'd236, 1'b1}) begin
      n_errors++;
      $display("FAIL lmiss: got miss=%0b x=%0d y=%0d srv=%0b want 1 316 236 1",
               miss_left, ball_x, ball_y, serving);
    end
    @(negedge clk);
    n_checks++;
    if (miss_left !== 1'b0) begin
      n_errors++;
      $display("FAIL lmiss_width: got miss=%0b want 0", miss_left);
    end
    repeat (60) do_tick(0);
    n_checks++;
    if (serving !== 1'b0 || ball_x !== 10'd316) begin
      n_errors++;
      $display("FAIL lmiss_serve: got srv=%0b x=%0d want 0 316", serving, ball_x);
    end
    do_tick(0);
    n_checks++;
    if (ball_x !== 10'd314) begin
      n_errors++;
      $display("FAIL lmiss_dir: got x=%0d want 314", ball_x);
    end
  endtask

  task automatic test_random();
    logic [13:0] got, want;
    for (int i = 0; i < 1500; i++) begin
      paddle_left_y  = 10'($urandom_range(0, 415));
      paddle_right_y = 10'($urandom_range(0, 415));
      do_tick($urandom_range(0, 2));
      got  = {ball_x, serving, hit_left, hit_right, miss_left};
      want = {10'(mx), (mmode == 0), e_hl, e_hr, e_ml};
      n_checks++;
      if (got !== want || ball_y !== 10'(my) || miss_right !== e_mr) begin
        n_errors++;
        $display("FAIL rand_%0d: got x=%0d y=%0d s=%0b p=%b want x=%0d y=%0d s=%0b p=%b",
                 i, ball_x, ball_y, serving,
                 {hit_left, hit_right, miss_left, miss_right},
                 mx, my, mmode == 0, {e_hl, e_hr, e_ml, e_mr});
      end
    end
  endtask

  task automatic test_reset_mid_serve();
    apply_reset();
    repeat (30) do_tick(0);
    apply_reset();
    for (int i = 1; i <= 60; i++) begin
      do_tick(0);
      if (i == 59) begin
        n_checks++;
        if (serving !== 1'b1) begin
          n_errors++;
          $display("FAIL rst_serve_59: got serving=%0b want 1", serving);
        end
      end
    end
    n_checks++;
    if (serving !== 1'b0 || ball_x !== 10'd316) begin
      n_errors++;
      $display("FAIL rst_serve_60: got srv=%0b x=%0d want 0 316", serving, ball_x);
    end
    do_tick(0);
    n_checks++;
    if (ball_x !== 10'd318) begin
      n_errors++;
      $display("FAIL rst_serve_move: got x=%0d want 318", ball_x);
    end
  endtask

  task automatic test_game_over();
    logic [9:0] fx, fy;
    int bad;
    repeat (5) do_tick(0);
    fx = ball_x;
    fy = ball_y;
    game_over = 1'b1;
    do_tick(0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      paddle_left_y  = 10'($urandom_range(0, 415));
      paddle_right_y = 10'($urandom_range(0, 415));
      do_tick(0);
      if ({ball_x, ball_y} !== {fx, fy} ||
          {hit_left, hit_right, miss_left, miss_right} !== 4'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || {ball_x, ball_y} !== {10'(mx), 10'(my)}) begin
      n_errors++;
      $display("FAIL halt_frozen: got %0d bad ticks x=%0d y=%0d want 0 %0d %0d",
               bad, ball_x, ball_y, mx, my);
    end
    n_checks++;
    if (serving !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_serving: got %0b want 0", serving);
    end
    game_over = 1'b0;
    do_tick(0);
    n_checks++;
    if ({ball_x, ball_y} !== {fx, fy}) begin
      n_errors++;
      $display("FAIL halt_sticky: got x=%0d y=%0d want %0d %0d",
               ball_x, ball_y, fx, fy);
    end
    apply_reset();
    n_checks++;
    if ({ball_x, ball_y, serving} !== {10'd316, 10'd236, 1'b1}) begin
      n_errors++;
      $display("FAIL halt_reset: got x=%0d y=%0d srv=%0b want 316 236 1",
               ball_x, ball_y, serving);
    end
  endtask

  initial begin
    reset          = 1'b1;
    frame_tick     = 1'b0;
    game_over      = 1'b0;
    paddle_left_y  = 10'd0;
    paddle_right_y = 10'd0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_serve_timing();
    test_bottom_wall();
    test_left_hit();
    test_left_miss();
    test_random();
    test_reset_mid_serve();
    test_game_over();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
